distance_calculator: RTL and testbench

Computes the integer Euclidean distance, floor(sqrt(dx²+dy²+dz²)), between two signed fixed-point 3-D LiDAR points. A 2-D mode ignores the z axis. It sits in the point-cloud denoising datapath: neighbour-search logic presents a reference point and a candidate point, pulses `start`, and compares the returned `distance` against a radius threshold. The square root is computed iteratively, one result bit per cycle, with a start/done handshake.

---
 rtl/distance_calculator.sv | 145 ++++++++++++++
 tb/tb_distance_calculator.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/distance_calculator.sv
// distance_calculator: floor(sqrt(dx^2+dy^2+dz^2)) between two signed 3-D
// points, with a 2-D mode that ignores z. The root is produced one bit per
// cycle with the restoring digit-by-digit method. A start/done handshake
// wraps the computation.
module distance_calculator #(
  parameter int N = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   point_x1,
  input  logic [N-1:0]   point_y1,
  input  logic [N-1:0]   point_z1,
  input  logic [N-1:0]   point_x2,
  input  logic [N-1:0]   point_y2,
  input  logic [N-1:0]   point_z2,
  input  logic           point_3d,
  output logic [N/2-1:0] distance,
  output logic           done,
  output logic           busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SQUARE, ROOT} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     dx_q, dx_d, dy_q, dy_d, dz_q, dz_d;
  logic [2*N+1:0]   rad_q, rad_d;
  logic [N+1:0]     rem_q, rem_d;
  logic [N:0]       root_q, root_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N/2-1:0]   dist_q, dist_d;
  logic             done_q, done_d;

  logic [2*N+1:0]   ex, ey, ez, sq_sum;
  logic [N+3:0]     rem_sh, trial;
  logic [N+1:0]     rem_nx;
  logic [N:0]       root_nx;
  logic [N/2-1:0]   dist_sat;

  // Magnitude of a signed difference; the N+1-bit subtraction cannot overflow.
  function automatic logic [N-1:0] absdiff(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] d;
    d = {a[N-1], a} - {b[N-1], b};
    return d[N] ? N'(-d) : d[N-1:0];
  endfunction

  // Sum of squares, zero-extended to 2N+2 bits so it never wraps.
  always_comb begin
    ex     = (2*N+2)'(dx_q);
    ey     = (2*N+2)'(dy_q);
    ez     = (2*N+2)'(dz_q);
    sq_sum = ex * ex + ey * ey + ez * ez;
  end

  // One restoring square-root step: bring down the next radicand bit pair.
  always_comb begin
    rem_sh = {rem_q, rad_q[2*N+1:2*N]};
    trial  = {1'b0, root_q, 2'b01};
    if (rem_sh >= trial) begin
      rem_nx  = (N+2)'(rem_sh - trial);
      root_nx = {root_q[N-1:0], 1'b1};
    end else begin
      rem_nx  = rem_sh[N+1:0];
      root_nx = {root_q[N-1:0], 1'b0};
    end
    dist_sat = (root_nx[N:N/2] != '0) ? '1 : root_nx[N/2-1:0];
  end

  // Next-state logic: capture, square, then N+1 root iterations.
  always_comb begin
    state_d = state_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    dz_d    = dz_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    dist_d  = dist_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dx_d    = absdiff(point_x1, point_x2);
          dy_d    = absdiff(point_y1, point_y2);
          dz_d    = point_3d ? absdiff(point_z1, point_z2) : '0;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        rad_d   = sq_sum;
        rem_d   = '0;
        root_d  = '0;
        cnt_d   = CW'(N);
        state_d = ROOT;
      end
      ROOT: begin
        rad_d  = {rad_q[2*N-1:0], 2'b00};
        rem_d  = rem_nx;
        root_d = root_nx;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          dist_d  = dist_sat;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      dx_q    <= '0;
      dy_q    <= '0;
      dz_q    <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      dist_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      dz_q    <= dz_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      dist_q  <= dist_d;
      done_q  <= done_d;
    end
  end

  assign distance = dist_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_distance_calculator.sv
// Self-checking bench for distance_calculator: directed cases plus random
// operands compared against an arithmetic reference model.
module tb_distance_calculator;

  localparam int N = 32;
  localparam int H = N / 2;

  logic         clock = 1'b0;
  logic         reset, start, p3d;
  logic [N-1:0] x1, y1, z1, x2, y2, z2;
  logic [H-1:0] distance;
  logic         done, busy;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  distance_calculator #(.N(N)) dut (
    .clock(clock), .reset(reset), .start(start),
    .point_x1(x1), .point_y1(y1), .point_z1(z1),
    .point_x2(x2), .point_y2(y2), .point_z2(z2),
    .point_3d(p3d), .distance(distance), .done(done), .busy(busy)
  );

  function automatic logic [67:0] sqmag(input logic [N-1:0] a, input logic [N-1:0] b);
    longint d;
    logic [67:0] m;
    d = longint'($signed(a)) - longint'($signed(b));
    if (d < 0) d = -d;
    m = 68'(d);
    return m * m;
  endfunction

  // Reference: largest r with r*r <= S, found bit by bit, then saturated.
  function automatic logic [H-1:0] model(input logic [N-1:0] ax, input logic [N-1:0] ay,
                                         input logic [N-1:0] az, input logic [N-1:0] bx,
                                         input logic [N-1:0] by, input logic [N-1:0] bz,
                                         input logic d3);
    logic [67:0] s, r, t;
    s = sqmag(ax, bx) + sqmag(ay, by);
    if (d3) s = s + sqmag(az, bz);
    r = '0;
    for (int b = 33; b >= 0; b--) begin
      t = r | (68'(1) << b);
      if (t * t <= s) r = t;
    end
    return (r > 68'((1 << H) - 1)) ? '1 : r[H-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic setp(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c,
                      input logic [N-1:0] d, input logic [N-1:0] e, input logic [N-1:0] f,
                      input logic m);
    x1 = a; y1 = b; z1 = c; x2 = d; y2 = e; z2 = f; p3d = m;
  endtask

  // Wait (bounded) for done; returns edges counted after the capture edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic op(input string tag, input logic [H-1:0] expd);
    int lat;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    check({tag, " busy"}, busy, 1);
    wait_done(lat);
    check({tag, " done"}, done, 1);
    check({tag, " latency"}, lat, N + 2);
    check({tag, " dist"}, distance, expd);
    @(posedge clock); #1;
    check({tag, " done pulse"}, done, 0);
    check({tag, " busy clear"}, busy, 0);
  endtask

  initial begin
    int lat, ndone;
    logic [H-1:0] got, expa;

    reset = 1'b1; start = 1'b0;
    setp('0, '0, '0, '0, '0, '0, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    check("reset dist", distance, 0);
    check("reset done", done, 0);
    check("reset busy", busy, 0);

    setp(0, 0, 0, 3, 4, 12, 1'b1);            op("pyth", 16'd13);
    setp(-5, -5, 100, -2, -1, -900, 1'b0);    op("2d neg", 16'd5);
    setp(-5, -5, 100, -2, -1, -900, 1'b1);    op("3d neg", 16'd1000);
    setp(0, 0, 0, 1, 1, 1, 1'b1);             op("floor1", 16'd1);
    setp(0, 0, 0, 2, 2, 2, 1'b1);             op("floor3", 16'd3);
    setp(4354, 818, 170, 6574, 844, 245, 1'b1); op("floor2221", 16'd2221);
    setp(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
         32'h80000000, 32'h80000000, 32'h80000000, 1'b1);
    op("saturate", 16'hFFFF);
    setp(123, -7, 99, 123, -7, 99, 1'b1);     op("identical", 16'd0);

    // Second start while busy must be ignored.
    setp(0, 0, 0, 3, 4, 12, 1'b1);
    expa = 16'd13;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock); setp(0, 0, 0, 300, 400, 0, 1'b1); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    ndone = 0; got = '0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1) begin
        ndone++;
        got = distance;
      end
    end
    check("busy start pulses", ndone, 1);
    check("busy start result", got, expa);

    // Start on the edge right after done is accepted.
    setp(0, 0, 0, 6, 8, 0, 1'b0);
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    wait_done(lat);
    check("b2b first done", done, 1);
    check("b2b first dist", distance, 10);
    setp(0, 0, 0, 5, 12, 0, 1'b0); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    check("b2b accepted", busy, 1);
    wait_done(lat);
    check("b2b second done", done, 1);
    check("b2b second latency", lat, N + 2);
    check("b2b second dist", distance, 13);

    // Reset mid-computation aborts.
    setp(0, 0, 0, 7, 24, 0, 1'b0);
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    check("abort dist", distance, 0);
    check("abort busy", busy, 0);
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1) ndone++;
    end
    check("abort no done", ndone, 0);
    op("after abort", 16'd25);

    // Random operands: alternate small-range and full-range coordinates.
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0)
        setp(N'($urandom_range(0, 4000)) - 2000, N'($urandom_range(0, 4000)) - 2000,
             N'($urandom_range(0, 4000)) - 2000, N'($urandom_range(0, 4000)) - 2000,
             N'($urandom_range(0, 4000)) - 2000, N'($urandom_range(0, 4000)) - 2000,
             1'($urandom_range(0, 1)));
      else
        setp(N'($urandom >> ($urandom_range(0, 3) * 5)), N'($urandom >> 10), N'($urandom),
             N'($urandom >> ($urandom_range(0, 3) * 5)), N'($urandom >> 10), N'($urandom),
             1'($urandom_range(0, 1)));
      op("random", model(x1, y1, z1, x2, y2, z2, p3d));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
